// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter slice.
package uart_pkg;

  localparam int BYTE_W = 8;
  localparam int MSG_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_ACK
  } tx_arb_state_t;

  // Message captured at grant; len=0 sends only the low byte.
  typedef struct packed {
    logic [MSG_W-1:0] data;
    logic             len;
  } tx_msg_t;

  function automatic int rr_wrap(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte handshake between the arbiter (master) and UART_TX (slave).
interface uart_tx_arbiter_if import uart_pkg::*; ();

   logic [BYTE_W-1:0] tx_p_data;
   logic              tx_data_valid;
   logic              tx_par_en;
   logic              tx_par_typ;
   logic              tx_busy;

   modport master (
      output tx_p_data, tx_data_valid, tx_par_en, tx_par_typ,
      input  tx_busy
   );

   modport slave (
      input  tx_p_data, tx_data_valid, tx_par_en, tx_par_typ,
      output tx_busy
   );

endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant, with wrap-around.
module rr_arbiter import uart_pkg::*; #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 3
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_grant,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               gnt_vld
);

   logic [NUM_REQ-1:0] rot;

   always_comb begin
      // Rotate so bit 0 is the requester just after last_grant.
      rot     = NUM_REQ'({req, req} >> (int'(last_grant) + 1));
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            gnt_vld = 1'b1;
            gnt_idx = IDX_W'(rr_wrap(int'(last_grant), i + 1, NUM_REQ));
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer sharing one UART_TX between NUM_REQ requesters.
// Optional busy-rise watchdog: define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter import uart_pkg::*; #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 3,
   parameter int TIMEOUT = 16
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [NUM_REQ-1:0]       req_vld,
   input  logic [MSG_W*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]       req_len,
   input  logic                     cfg_par_en,
   input  logic                     cfg_par_typ,
   uart_tx_arbiter_if.master        tx,
   output logic [NUM_REQ-1:0]       req_ack,
   output logic [IDX_W-1:0]         grant_idx,
   output logic                     arb_busy,
   output logic                     tx_err
);

   if (NUM_REQ < 2 || NUM_REQ > 8 || (2 ** IDX_W) < NUM_REQ || TIMEOUT < 1) begin : g_param_chk
      $error("uart_tx_arbiter: illegal parameter set");
   end

   tx_arb_state_t      state;
   tx_msg_t            msg;
   tx_msg_t            sel_msg;
   logic               byte_cnt;
   logic [IDX_W-1:0]   last_grant;
   logic [IDX_W-1:0]   arb_idx;
   logic               arb_vld;
   logic [NUM_REQ-1:0] ack_onehot;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
      .req        (req_vld),
      .last_grant (last_grant),
      .gnt_idx    (arb_idx),
      .gnt_vld    (arb_vld)
   );

   always_comb begin
      sel_msg    = '0;
      ack_onehot = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_idx == IDX_W'(i)) begin
            sel_msg = '{data: req_data[i*MSG_W +: MSG_W], len: req_len[i]};
         end
         ack_onehot[i] = (grant_idx == IDX_W'(i));
      end
   end

`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);
   logic [TO_W-1:0] to_cnt;
`else
   assign tx_err = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         state            <= ST_IDLE;
         msg              <= '0;
         byte_cnt         <= 1'b0;
         last_grant       <= IDX_W'(NUM_REQ - 1);
         grant_idx        <= '0;
         req_ack          <= '0;
         arb_busy         <= 1'b0;
         tx.tx_p_data     <= '0;
         tx.tx_data_valid <= 1'b0;
         tx.tx_par_en     <= 1'b0;
         tx.tx_par_typ    <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
         to_cnt           <= '0;
         tx_err           <= 1'b0;
`endif
      end else begin
         // NOTE: pulse outputs default low here; a later non-blocking assignment in the case raises them for one cycle.
         tx.tx_data_valid <= 1'b0;
         req_ack          <= '0;

         unique case (state)
            ST_IDLE: begin
               if (arb_vld) begin
                  grant_idx     <= arb_idx;
                  msg           <= sel_msg;
                  byte_cnt      <= 1'b0;
                  tx.tx_par_en  <= cfg_par_en;
                  tx.tx_par_typ <= cfg_par_typ;
                  arb_busy      <= 1'b1;
                  state         <= ST_LOAD;
               end
            end

            ST_LOAD: begin
               if (!tx.tx_busy) begin
                  tx.tx_p_data     <= msg.data[BYTE_W-1:0];
                  tx.tx_data_valid <= 1'b1;
                  state            <= ST_SEND;
               end
            end

            ST_SEND: begin
`ifdef UART_TX_ARB_TIMEOUT_EN
               to_cnt <= '0;
`endif
               state  <= ST_WAIT_HI;
            end

            ST_WAIT_HI: begin
               if (tx.tx_busy) begin
                  state <= ST_WAIT_LO;
               end
`ifdef UART_TX_ARB_TIMEOUT_EN
               else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                  tx_err  <= 1'b1;
                  req_ack <= ack_onehot;
                  state   <= ST_ACK;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
`endif
            end

            ST_WAIT_LO: begin
               if (!tx.tx_busy) begin
                  if (byte_cnt < msg.len) begin
                     byte_cnt         <= 1'b1;
                     tx.tx_p_data     <= msg.data[BYTE_W +: BYTE_W];
                     tx.tx_data_valid <= 1'b1;
                     state            <= ST_SEND;
                  end else begin
                     req_ack <= ack_onehot;
                     state   <= ST_ACK;
                  end
               end
            end

            ST_ACK: begin
               last_grant <= grant_idx;
               arb_busy   <= 1'b0;
               state      <= ST_IDLE;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural UART_TX busy model.
module tb_uart_tx_arbiter;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [1:0]  req_vld = '0;
   logic [31:0] req_data = '0;
   logic [1:0]  req_len = '0;
   logic        cfg_par_en = 1'b0;
   logic        cfg_par_typ = 1'b0;
   logic [1:0]  req_ack;
   logic [2:0]  grant_idx;
   logic        arb_busy;
   logic        tx_err;

   int errors = 0;
   int checks = 0;

   uart_tx_arbiter_if bus ();

   uart_tx_arbiter #(.NUM_REQ(2), .IDX_W(3), .TIMEOUT(16)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .req_vld     (req_vld),
      .req_data    (req_data),
      .req_len     (req_len),
      .cfg_par_en  (cfg_par_en),
      .cfg_par_typ (cfg_par_typ),
      .tx          (bus),
      .req_ack     (req_ack),
      .grant_idx   (grant_idx),
      .arb_busy    (arb_busy),
      .tx_err      (tx_err)
   );

   always #5 CLK = ~CLK;

   // UART_TX model: busy rises the cycle after Data_Valid and stays high 11 cycles.
   bit model_on = 1'b1;
   bit pend = 1'b0;
   int busy_left = 0;
   initial bus.tx_busy = 1'b0;
   always @(negedge CLK) begin
      if (busy_left > 0) begin
         busy_left = busy_left - 1;
         if (busy_left == 0) bus.tx_busy = 1'b0;
      end
      if (pend) begin
         pend = 1'b0;
         bus.tx_busy = 1'b1;
         busy_left = 11;
      end
      if (model_on && bus.tx_data_valid) pend = 1'b1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed=no finish expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Runs until req_ack is seen or max_cyc expires (ack=0, ack_cyc=-1).
   task automatic run_msg(input int max_cyc, input int drop_at, input int flip_at,
                          input logic exp_pe, input logic exp_pt,
                          output logic [1:0] ack, output int ack_cyc, output int n_dv,
                          output logic [7:0] b0, output logic [7:0] b1,
                          output int dv0, output int dv1, output int par_bad);
      ack = '0; ack_cyc = -1; n_dv = 0; b0 = '0; b1 = '0; dv0 = -1; dv1 = -1; par_bad = 0;
      for (int c = 1; c <= max_cyc; c++) begin
         step();
         if (c == drop_at) req_vld = '0;
         if (c == flip_at) begin
            cfg_par_en  = ~cfg_par_en;
            cfg_par_typ = ~cfg_par_typ;
         end
         if (bus.tx_data_valid) begin
            if (n_dv == 0) begin b0 = bus.tx_p_data; dv0 = c; end
            else           begin b1 = bus.tx_p_data; dv1 = c; end
            n_dv++;
         end
         if (arb_busy && (bus.tx_par_en !== exp_pe || bus.tx_par_typ !== exp_pt)) par_bad++;
         if (req_ack != 2'b00) begin
            ack = req_ack;
            ack_cyc = c;
            break;
         end
      end
   endtask

   logic [1:0] ack;
   logic [7:0] b0, b1;
   int ack_cyc, n_dv, dv0, dv1, par_bad, stray;

   initial begin
      // Reset
      repeat (3) step();
      check("rst_p_data", bus.tx_p_data, 8'h00);
      check("rst_dv", bus.tx_data_valid, 1'b0);
      check("rst_par", {bus.tx_par_en, bus.tx_par_typ}, 2'b00);
      check("rst_ack", req_ack, 2'b00);
      check("rst_grant", grant_idx, 3'd0);
      check("rst_busy", arb_busy, 1'b0);
      check("rst_err", tx_err, 1'b0);
      RST = 1'b0;
      step();

      // 1: single 1-byte message
      req_data = 32'h0000_00A5; req_len = 2'b00; req_vld = 2'b01;
      run_msg(40, 0, 0, 1'b0, 1'b0, ack, ack_cyc, n_dv, b0, b1, dv0, dv1, par_bad);
      check("t1_ack", ack, 2'b01);
      check("t1_ack_cyc", ack_cyc, 15);
      check("t1_n_dv", n_dv, 1);
      check("t1_byte", b0, 8'hA5);
      check("t1_dv_lat", dv0, 2);
      check("t1_grant", grant_idx, 3'd0);
      req_vld = '0;
      step();
      check("t1_idle", arb_busy, 1'b0);
      check("t1_hold", bus.tx_p_data, 8'hA5);

      // 2: two-byte message on requester 1
      req_data = 32'h1234_0000; req_len = 2'b10; req_vld = 2'b10;
      run_msg(60, 0, 0, 1'b0, 1'b0, ack, ack_cyc, n_dv, b0, b1, dv0, dv1, par_bad);
      check("t2_ack", ack, 2'b10);
      check("t2_ack_cyc", ack_cyc, 28);
      check("t2_n_dv", n_dv, 2);
      check("t2_b0", b0, 8'h34);
      check("t2_b1", b1, 8'h12);
      check("t2_dv1", dv1, 15);
      check("t2_grant", grant_idx, 3'd1);
      req_vld = '0;
      step();
      check("t2_idle", arb_busy, 1'b0);

      // 3: contention, both held: grants 0,1,0,1
      req_data = 32'hFF3C_00C3; req_len = 2'b00; req_vld = 2'b11;
      for (int k = 0; k < 4; k++) begin
         run_msg(40, 0, 0, 1'b0, 1'b0, ack, ack_cyc, n_dv, b0, b1, dv0, dv1, par_bad);
         check($sformatf("t3_ack%0d", k), ack, (k % 2) ? 2'b10 : 2'b01);
         check($sformatf("t3_grant%0d", k), grant_idx, (k % 2) ? 3'd1 : 3'd0);
         check($sformatf("t3_byte%0d", k), b0, (k % 2) ? 8'h3C : 8'hC3);
         check($sformatf("t3_cyc%0d", k), ack_cyc, (k == 0) ? 15 : 16);
      end
      req_vld = '0;
      step();
      check("t3_idle", arb_busy, 1'b0);

      // 4: config latched at grant, toggled mid-message; req dropped after grant
      cfg_par_en = 1'b1; cfg_par_typ = 1'b1;
      req_data = 32'h0000_BEEF; req_len = 2'b01; req_vld = 2'b01;
      run_msg(60, 3, 5, 1'b1, 1'b1, ack, ack_cyc, n_dv, b0, b1, dv0, dv1, par_bad);
      check("t4_ack", ack, 2'b01);
      check("t4_ack_cyc", ack_cyc, 28);
      check("t4_b0", b0, 8'hEF);
      check("t4_b1", b1, 8'hBE);
      check("t4_par_stable", par_bad, 0);
      cfg_par_en = 1'b0; cfg_par_typ = 1'b0;
      step();
      check("t4_idle", arb_busy, 1'b0);

      // 5: reset during WAIT_LO of byte 0
      req_data = 32'h7788_0000; req_len = 2'b10; req_vld = 2'b10;
      repeat (8) step();
      check("t5_busy_pre", arb_busy, 1'b1);
      RST = 1'b1;
      step();
      check("t5_p_data", bus.tx_p_data, 8'h00);
      check("t5_dv", bus.tx_data_valid, 1'b0);
      check("t5_par", {bus.tx_par_en, bus.tx_par_typ}, 2'b00);
      check("t5_ack", req_ack, 2'b00);
      check("t5_grant", grant_idx, 3'd0);
      check("t5_busy", arb_busy, 1'b0);
      RST = 1'b0; req_vld = '0;
      stray = 0;
      for (int c = 0; c < 30; c++) begin
         step();
         if (req_ack != 2'b00 || bus.tx_data_valid) stray++;
      end
      check("t5_no_ack", stray, 0);

      // 6: tx_busy stuck low
      model_on = 1'b0;
      req_data = 32'h0000_0011; req_len = 2'b00; req_vld = 2'b01;
`ifdef UART_TX_ARB_TIMEOUT_EN
      run_msg(40, 0, 0, 1'b0, 1'b0, ack, ack_cyc, n_dv, b0, b1, dv0, dv1, par_bad);
      check("t6_ack", ack, 2'b01);
      check("t6_ack_cyc", ack_cyc, 19);
      check("t6_n_dv", n_dv, 1);
      check("t6_err", tx_err, 1'b1);
      req_vld = '0;
      step();
      check("t6_idle", arb_busy, 1'b0);
      check("t6_err_sticky", tx_err, 1'b1);
      RST = 1'b1;
      step();
      RST = 1'b0;
      check("t6_err_clr", tx_err, 1'b0);
`else
      run_msg(40, 0, 0, 1'b0, 1'b0, ack, ack_cyc, n_dv, b0, b1, dv0, dv1, par_bad);
      check("t6_no_ack", ack, 2'b00);
      check("t6_n_dv", n_dv, 1);
      check("t6_stuck", arb_busy, 1'b1);
      check("t6_err", tx_err, 1'b0);
      RST = 1'b1; req_vld = '0;
      step();
      RST = 1'b0;
      check("t6_idle", arb_busy, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter and byte sequencer that shares one UART_TX instance between NUM_REQ requesters (e.g. register-file read path, ALU result path).
- Accepts a 1- or 2-byte message from the granted requester and latches it. Feeds the message byte by byte into UART_TX over the P_DATA/Data_Valid/busy handshake. Acknowledges the requester once its last frame has finished.
- Sits in the UART clock domain, directly upstream of UART_TX.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- IDX_W, 3, width of grant index. Must satisfy 2^IDX_W >= NUM_REQ.
- TIMEOUT, 16, cycles allowed between a Data_Valid pulse and busy rising (used only with the optional feature).

Ports:
- CLK  in  1  UART clock.
- RST  in  1  synchronous reset, active-high.
- req_vld  in  NUM_REQ  per-requester request. Level, held until the matching ack.
- req_data  in  16*NUM_REQ  per-requester payload. Slice i = [16i+15:16i]. Low byte is sent first.
- req_len  in  NUM_REQ  0 = 1 byte (low byte only), 1 = 2 bytes.
- cfg_par_en  in  1  parity enable, sampled at grant.
- cfg_par_typ  in  1  parity type, sampled at grant.
- tx_busy  in  1  busy from UART_TX.
- tx_p_data  out  8  P_DATA to UART_TX.
- tx_data_valid  out  1  Data_Valid to UART_TX. Single-cycle pulse.
- tx_par_en  out  1  PAR_EN to UART_TX, held for the whole message.
- tx_par_typ  out  1  PAR_TYP to UART_TX, held for the whole message.
- req_ack  out  NUM_REQ  one-hot, one-cycle pulse when message i is complete.
- grant_idx  out  IDX_W  index of the current or last granted requester.
- arb_busy  out  1  high in any state other than IDLE.
- tx_err  out  1  sticky timeout flag (optional feature). Tied 0 otherwise.

Behaviour:
- Reset values, all outputs 0:
  - tx_p_data=0, tx_data_valid=0, tx_par_en=0, tx_par_typ=0, req_ack=0, grant_idx=0, arb_busy=0, tx_err=0.
  - Round-robin pointer resets so that requester 0 has the highest priority first.
- FSM states: IDLE, LOAD, SEND, WAIT_HI, WAIT_LO, ACK.
- IDLE:
  - If any req_vld is high, choose the first set bit searching from (last_grant+1) mod NUM_REQ upward, with wrap-around, then go to LOAD.
  - The chosen index is registered into grant_idx.
- LOAD:
  - Latch req_data slice, req_len, cfg_par_en and cfg_par_typ.
  - Set byte_cnt=0. Drive tx_par_en/tx_par_typ from the latched values.
  - Go to SEND only when tx_busy=0; otherwise stay in LOAD.
- SEND:
  - tx_data_valid=1 for exactly one cycle. tx_p_data = byte[byte_cnt], i.e. low byte when byte_cnt=0.
  - Go to WAIT_HI.
- WAIT_HI: wait for tx_busy=1, then go to WAIT_LO.
- WAIT_LO:
  - Wait for tx_busy=0.
  - If byte_cnt < req_len: byte_cnt++ and go to SEND. The next Data_Valid is driven in the cycle after busy falls.
  - Otherwise go to ACK.
- ACK:
  - req_ack[grant_idx]=1 for one cycle. Update last_grant=grant_idx. Return to IDLE.
  - A new grant is decided no earlier than the cycle after ACK.
- tx_p_data holds its last value outside SEND. tx_par_en/tx_par_typ stay stable from LOAD through ACK.
- Latency: req_vld rise in IDLE -> first tx_data_valid after 2 cycles (IDLE->LOAD->SEND), provided tx_busy=0.
- Boundary conditions:
  - Simultaneous requests: round-robin order is strict, with no starvation.
  - A single active requester is re-granted back-to-back.
  - req_vld dropped after grant: the latched message is still sent and acked.
  - cfg_* changes mid-message are ignored until the next LOAD.
  - RST asserted mid-frame: FSM goes to IDLE, all outputs are cleared, no ack is issued. Any UART_TX frame in progress is the TX's own concern.

Optional Feature:
- Macro: UART_TX_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter runs in WAIT_HI.
  - If tx_busy has not risen after TIMEOUT cycles: set tx_err (sticky until RST), skip the message, pulse req_ack for the granted requester, return to IDLE.
- Without the macro: no counter; WAIT_HI waits indefinitely; tx_err is tied to 0.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding typedef (tx_arb_state_t).
  - Constant BYTE_W=8.
  - Constant MSG_W=16.
- One sub-module, rr_arbiter:
  - Inputs: req vector and last_grant.
  - Output: next grant index and a valid flag.
  - Purely combinational priority rotate; the FSM registers its result.

Test Plan:
1. Single 1-byte message: req_vld[0]=1, req_data[7:0]=0xA5, len=0, tx_busy model asserts busy 1 cycle after Data_Valid for 11 cycles.
   -> one Data_Valid with tx_p_data=0xA5, then req_ack[0] pulse, arb_busy returns to 0.
2. Two-byte message: req_vld[1]=1, data=0x1234, len=1.
   -> Data_Valid with 0x34, then Data_Valid with 0x12 one cycle after busy falls, then one req_ack[1].
3. Contention: req_vld=2'b11 held continuously.
   -> grants alternate 0,1,0,1 and each ack goes to the matching requester.
4. Config latch: cfg_par_en=1, cfg_par_typ=1 at grant, toggled mid-message.
   -> tx_par_en/tx_par_typ stay 1/1 until ACK.
5. Reset mid-message: RST pulsed during WAIT_LO of byte 0.
   -> next cycle all outputs are 0, FSM is IDLE, no req_ack is issued.
6. Timeout (UART_TX_ARB_TIMEOUT_EN defined): tx_busy stuck at 0.
   -> after TIMEOUT=16 cycles tx_err=1, req_ack pulses, FSM returns to IDLE.
